// File: rtl/pulse_stretcher_pkg.sv
// Shared definitions for the pulse stretcher: FSM state encodings and a
// width helper used to size the window counter and the pending queue count.
package pulse_stretcher_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_HOLD = 2'd1,
        ST_GAP  = 2'd2
    } state_t;

    // Bits needed to encode values 0..max_value-1, never less than one bit.
    function automatic int width_for(input int max_value);
        return (max_value <= 1) ? 1 : $clog2(max_value);
    endfunction

endpackage

// File: rtl/pulse_stretcher_if.sv
// Event/level bundle between a pulse source and the pulse stretcher.
// The master side drives event strobes; the slave side returns the
// stretched level plus status.
interface pulse_stretcher_if #(
    parameter int PEND_MAX = 3
);
    localparam int PEND_W = pulse_stretcher_pkg::width_for(PEND_MAX + 1);

    logic              pulse_in;
    logic              level_out;
    logic              busy;
    logic [PEND_W-1:0] pending;
    logic              drop;

    modport master (
        output pulse_in,
        input  level_out,
        input  busy,
        input  pending,
        input  drop
    );

    modport slave (
        input  pulse_in,
        output level_out,
        output busy,
        output pending,
        output drop
    );
endinterface

// File: rtl/pulse_stretcher_sat_counter.sv
// Saturating up/down counter. Simultaneous inc and dec cancel out; an
// increment attempted at MAX leaves the count alone and raises a one-cycle
// overflow strobe. Decrement at zero is ignored.
module sat_counter #(
    parameter int MAX   = 3,
    parameter int WIDTH = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inc,
    input  logic             dec,
    output logic [WIDTH-1:0] count,
    output logic             overflow
);

    localparam logic [WIDTH-1:0] MAX_VAL = WIDTH'(MAX);

    // Count update with saturation at both ends and a registered overflow flag.
    always_ff @(posedge clk) begin
        if (rst) begin
            count    <= '0;
            overflow <= 1'b0;
        end else begin
            overflow <= 1'b0;
            if (inc && !dec) begin
                if (count == MAX_VAL) begin
                    overflow <= 1'b1;
                end else begin
                    count <= count + WIDTH'(1);
                end
            end else if (dec && !inc) begin
                if (count != '0) begin
                    count <= count - WIDTH'(1);
                end
            end
        end
    end

endmodule

// File: rtl/pulse_stretcher.sv
// Turns single-cycle event strobes into fixed-width high windows, each
// followed by a forced low gap. Events arriving while a window or gap is
// running are queued so every event still gets its own window.
module pulse_stretcher
    import pulse_stretcher_pkg::*;
#(
    parameter int HOLD_CYCLES = 4,
    parameter int GAP_CYCLES  = 2,
    parameter int PEND_MAX    = 3
) (
    input  logic              clk,
    input  logic              rst,
    pulse_stretcher_if.slave  bus
);

    localparam int CNT_MAX = (HOLD_CYCLES > GAP_CYCLES) ? HOLD_CYCLES : GAP_CYCLES;
    localparam int CNT_W   = width_for(CNT_MAX);
    localparam int PEND_W  = width_for(PEND_MAX + 1);

    localparam logic [CNT_W-1:0] HOLD_LOAD = CNT_W'(HOLD_CYCLES - 1);
    localparam logic [CNT_W-1:0] GAP_LOAD  = CNT_W'(GAP_CYCLES - 1);

    state_t            state;
    logic [CNT_W-1:0]  counter;
    logic              level_q;
    logic              busy_q;
    logic [PEND_W-1:0] pending_q;
    logic              drop_q;

    logic cnt_zero;
    logic have_pending;
    logic gap_end;
    logic pend_inc;
    logic pend_dec;

    // Queue bookkeeping: events seen mid-window or mid-gap are queued, and a
    // queued event is consumed when the gap ends into a new window.
    always_comb begin
        cnt_zero     = (counter == '0);
        have_pending = (pending_q != '0);
        gap_end      = (state == ST_GAP) && cnt_zero;
        pend_inc     = bus.pulse_in &&
                       ((state == ST_HOLD) || ((state == ST_GAP) && !cnt_zero));
        pend_dec     = gap_end && have_pending;
    end

    sat_counter #(
        .MAX   (PEND_MAX),
        .WIDTH (PEND_W)
    ) u_pending (
        .clk      (clk),
        .rst      (rst),
        .inc      (pend_inc),
        .dec      (pend_dec),
        .count    (pending_q),
        .overflow (drop_q)
    );

    // Window FSM sharing one down-counter between the high window and the gap.
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= ST_IDLE;
            counter <= '0;
            level_q <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (bus.pulse_in) begin
                        state   <= ST_HOLD;
                        counter <= HOLD_LOAD;
                        level_q <= 1'b1;
                        busy_q  <= 1'b1;
                    end
                end
                ST_HOLD: begin
                    if (!cnt_zero) begin
                        counter <= counter - CNT_W'(1);
                    end else begin
                        state   <= ST_GAP;
                        counter <= GAP_LOAD;
                        level_q <= 1'b0;
                    end
                end
                ST_GAP: begin
                    if (!cnt_zero) begin
                        counter <= counter - CNT_W'(1);
                    end else if (have_pending || bus.pulse_in) begin
                        state   <= ST_HOLD;
                        counter <= HOLD_LOAD;
                        level_q <= 1'b1;
                    end else begin
                        state   <= ST_IDLE;
                        counter <= '0;
                        busy_q  <= 1'b0;
                    end
                end
                default: begin
                    state   <= ST_IDLE;
                    counter <= '0;
                    level_q <= 1'b0;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.level_out = level_q;
    assign bus.busy      = busy_q;
    assign bus.pending   = pending_q;
    assign bus.drop      = drop_q;

endmodule

// File: tb/tb_pulse_stretcher.sv
// Directed bench for pulse_stretcher: one default-parameter instance and one
// minimal instance (HOLD=1, GAP=1, no queue), each checked cycle by cycle
// against hand-derived window tables.
module tb_pulse_stretcher;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    pulse_stretcher_if #(.PEND_MAX(3)) bus_a ();
    pulse_stretcher_if #(.PEND_MAX(0)) bus_b ();

    pulse_stretcher #(
        .HOLD_CYCLES (4),
        .GAP_CYCLES  (2),
        .PEND_MAX    (3)
    ) dut_a (
        .clk (clk),
        .rst (rst),
        .bus (bus_a)
    );

    pulse_stretcher #(
        .HOLD_CYCLES (1),
        .GAP_CYCLES  (1),
        .PEND_MAX    (0)
    ) dut_b (
        .clk (clk),
        .rst (rst),
        .bus (bus_b)
    );

    int assert_count = 0;
    int fail_count   = 0;

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        assert_count++;
        if (observed !== expected) begin
            fail_count++;
            $display("[TB] FAIL %s: got %0d, expected %0d", tag, observed, expected);
        end
    endtask

    // Drive one cycle's inputs, then land 1 time unit after the next edge.
    task automatic applyStimulus(input bit rst_v, input bit pa, input bit pb);
        rst            = rst_v;
        bus_a.pulse_in = pa;
        bus_b.pulse_in = pb;
        @(posedge clk);
        #1;
    endtask

    task automatic checkA(input int sc, input int c, input bit lvl, input bit bsy,
                          input int pend, input bit drp);
        checkOutput($sformatf("s%0d_level@%0d", sc, c), 32'(bus_a.level_out), 32'(lvl));
        checkOutput($sformatf("s%0d_busy@%0d", sc, c), 32'(bus_a.busy), 32'(bsy));
        checkOutput($sformatf("s%0d_pending@%0d", sc, c), 32'(bus_a.pending), 32'(pend));
        checkOutput($sformatf("s%0d_drop@%0d", sc, c), 32'(bus_a.drop), 32'(drp));
    endtask

    task automatic checkB(input int sc, input int c, input bit lvl, input bit bsy,
                          input int pend, input bit drp);
        checkOutput($sformatf("s%0d_level@%0d", sc, c), 32'(bus_b.level_out), 32'(lvl));
        checkOutput($sformatf("s%0d_busy@%0d", sc, c), 32'(bus_b.busy), 32'(bsy));
        checkOutput($sformatf("s%0d_pending@%0d", sc, c), 32'(bus_b.pending), 32'(pend));
        checkOutput($sformatf("s%0d_drop@%0d", sc, c), 32'(bus_b.drop), 32'(drp));
    endtask

    // Each scenario: cycle c is the cycle whose outputs are checked at the top
    // of iteration c and whose inputs are sampled at the edge ending it.
    // Reset is held for cycles 0-3.
    initial begin
        int pend;
        rst            = 1'b1;
        bus_a.pulse_in = 1'b0;
        bus_b.pulse_in = 1'b0;
        @(posedge clk);
        #1;

        // Scenario 1: single pulse at 10.
        for (int c = 0; c <= 24; c++) begin
            if (c >= 1)
                checkA(1, c, (c >= 11 && c <= 14), (c >= 11 && c <= 16), 0, 1'b0);
            applyStimulus(c < 4, c == 10, 1'b0);
        end

        // Scenario 2: pulses at 10 and 12, second one queued.
        for (int c = 0; c <= 26; c++) begin
            if (c >= 1)
                checkA(2, c, (c >= 11 && c <= 14) || (c >= 17 && c <= 20),
                       (c >= 11 && c <= 22), (c >= 13 && c <= 16) ? 1 : 0, 1'b0);
            applyStimulus(c < 4, (c == 10) || (c == 12), 1'b0);
        end

        // Scenario 3: pulse on the last gap cycle is consumed directly.
        for (int c = 0; c <= 26; c++) begin
            if (c >= 1)
                checkA(3, c, (c >= 11 && c <= 14) || (c >= 17 && c <= 20),
                       (c >= 11 && c <= 22), 0, 1'b0);
            applyStimulus(c < 4, (c == 10) || (c == 16), 1'b0);
        end

        // Scenario 4: six back-to-back events, queue saturates, two dropped.
        for (int c = 0; c <= 38; c++) begin
            pend = (c == 12) ? 1 : (c == 13) ? 2 : (c >= 14 && c <= 16) ? 3 :
                   (c >= 17 && c <= 22) ? 2 : (c >= 23 && c <= 28) ? 1 : 0;
            if (c >= 1)
                checkA(4, c, (c >= 11 && c <= 14) || (c >= 17 && c <= 20) ||
                             (c >= 23 && c <= 26) || (c >= 29 && c <= 32),
                       (c >= 11 && c <= 34), pend, (c == 15) || (c == 16));
            applyStimulus(c < 4, (c >= 10 && c <= 15), 1'b0);
        end

        // Scenario 5: reset mid-window with two queued, pulses during reset ignored.
        for (int c = 0; c <= 25; c++) begin
            pend = (c == 11) ? 1 : (c == 12) ? 2 : 0;
            if (c >= 1)
                checkA(5, c, (c >= 10 && c <= 12), (c >= 10 && c <= 12), pend, 1'b0);
            applyStimulus((c < 4) || (c >= 12 && c <= 14), (c >= 9 && c <= 14), 1'b0);
        end

        // Scenario 6: HOLD=1, GAP=1, no queue; second pulse dropped, third
        // lands on the gap's only cycle and starts a window.
        for (int c = 0; c <= 20; c++) begin
            if (c >= 1)
                checkB(6, c, (c == 11) || (c == 13), (c >= 11 && c <= 14), 0, c == 12);
            applyStimulus(c < 4, 1'b0, (c >= 10 && c <= 12));
        end

        $display("End of test - %0d assertions evaluated, %0d failures",
                 assert_count, fail_count);
        $finish;
    end

endmodule

// File: doc/pulse_stretcher.md
Name: pulse_stretcher

Overview:
- Converts single-cycle event pulses (e.g. debounced key pulses) back into fixed-width level windows for slow consumers such as LEDs, buzzer enables and 7-seg flash.
- Each accepted input pulse produces exactly one output high window of HOLD_CYCLES, followed by a mandatory low gap of GAP_CYCLES.
- Pulses that arrive while busy are queued in a saturating pending counter, so every event yields a distinct output window.

Parameters:
- HOLD_CYCLES, default 4: output high duration per event, in clk cycles. Must be >=1.
- GAP_CYCLES, default 2: forced low duration after each window. Must be >=1.
- PEND_MAX, default 3: maximum queued events. Must be >=0; 0 means no queueing.

Ports:
- clk  input  1  system clock
- rst  input  1  synchronous, active-high reset
- pulse_in  input  1  event strobe; each high cycle counts as one event
- level_out  output  1  stretched level, registered
- busy  output  1  high when state is not IDLE
- pending  output  $clog2(PEND_MAX+1) (min 1)  queued event count
- drop  output  1  one-cycle strobe: an event was discarded because the queue was full

Behaviour:
- Reset (rst=1 at a clk edge): state=IDLE, counter=0, pending=0, level_out=0, busy=0, drop=0.
  - pulse_in is ignored during reset.
  - Reset mid-window aborts it immediately; level_out is 0 in the following cycle.
- All outputs are registered. level_out equals (state==HOLD).
- FSM states: IDLE, HOLD, GAP. A single down-counter of width $clog2(max(HOLD_CYCLES,GAP_CYCLES)) serves both HOLD and GAP.
- IDLE:
  - pulse_in=1 -> HOLD, counter=HOLD_CYCLES-1.
  - Latency is 1 cycle: pulse sampled at edge N gives level_out=1 from cycle N+1.
- HOLD:
  - counter!=0 -> decrement.
  - counter==0 -> GAP, counter=GAP_CYCLES-1.
  - level_out is high for exactly HOLD_CYCLES cycles.
- GAP:
  - counter!=0 -> decrement.
  - counter==0 and (pending>0 or pulse_in=1) -> HOLD, counter=HOLD_CYCLES-1.
  - counter==0 otherwise -> IDLE.
- Pending update, applied in the same cycle as the state logic:
  - Increment: pulse_in=1 while in HOLD, or while in GAP with counter!=0.
  - Decrement: leaving GAP into HOLD while pending>0.
  - Simultaneous inc and dec (GAP end, pending>0, pulse_in=1): pending is unchanged.
  - GAP end with pending==0 and pulse_in=1: the event is consumed directly and pending stays 0.
  - Saturation: an increment at pending==PEND_MAX with no simultaneous decrement leaves pending unchanged and drop=1 in the next cycle. drop is otherwise 0.
- Back-to-back windows are always separated by exactly GAP_CYCLES low cycles.
- busy=1 in HOLD and GAP. busy=0 only in IDLE.

Decomposition:
- Shared package/include: state encodings (ST_IDLE=2'd0, ST_HOLD=2'd1, ST_GAP=2'd2) and a width helper for counter and pending sizing.
- One natural sub-module, sat_counter: a saturating up/down counter with parameterised MAX, inc/dec inputs and an overflow strobe. It is used for pending.
- The FSM and the down-counter stay in the top module.

Test Plan (HOLD_CYCLES=4, GAP_CYCLES=2, PEND_MAX=3; rst released before cycle 5):
- Single pulse_in at cycle 10 -> level_out=1 cycles 11-14, 0 from 15; busy=1 cycles 11-16; IDLE at 17; pending stays 0.
- Pulses at cycles 10 and 12 -> pending=1 cycles 13-16; second window level_out=1 cycles 17-20; busy drops at 23; pending=0 from 17.
- Pulse at cycle 16 only (GAP last cycle, pending=0) -> immediate second window 17-20; pending never leaves 0.
- pulse_in high for cycles 10-15 (6 events) -> event 1 starts a window; events 2-4 queue (pending reaches 3 at 14); events 5-6 drop (drop=1 at 15 and 16); exactly 4 windows, starting 11, 17, 23 and 29.
- rst asserted at cycle 12 during HOLD with pending=2 -> cycle 13: level_out=0, busy=0, pending=0; no further windows; pulse_in during rst produces nothing.
- Parameter sweep HOLD_CYCLES=1, GAP_CYCLES=1, PEND_MAX=0 -> pulses at 10 and 11: window at 11 only; drop=1 at 12; pulse at 12 (GAP end) gives a window at 13.
